match_pe_pipe: RTL and testbench

- Fixed-latency byte-compare pipeline inside a match PE.
- Keeps two banked copies of the sliding window: a head copy and a history copy.
- Each issued beat reads MATCH_PE_WIDTH bytes at an unaligned head address and at an unaligned history address, then reports how many leading bytes match.
- Tag fields (idx, last) travel with each beat unchanged, so the scoreboard can accumulate results.

---
 rtl/match_pe_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_match_pe_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_pe_pipe.sv
// ============================================================================
// Module   : match_pe_pipe
// Brief    : Fixed-latency banked byte-compare pipeline for a match PE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 15
`endif
`ifndef MATCH_PE_WIDTH
`define MATCH_PE_WIDTH 8
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 3
`endif

module match_pe_pipe #(
    parameter int SCOREBOARD_ENTRY_INDEX = 1,
    parameter int NBPIPE                 = 3,
    parameter int SIZE_LOG2              = 15
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_valid,
    input  logic [SCOREBOARD_ENTRY_INDEX-1:0]    i_idx,
    input  logic                                 i_last,
    input  logic [`ADDR_WIDTH-1:0]               i_head_addr,
    input  logic [`ADDR_WIDTH-1:0]               i_history_addr,
    output logic                                 o_valid,
    output logic                                 o_last,
    output logic [SCOREBOARD_ENTRY_INDEX-1:0]    o_idx,
    output logic [`MAX_MATCH_LEN_LOG2:0]         o_match_len,
    input  logic [`ADDR_WIDTH-1:0]               i_write_addr,
    input  logic [`MATCH_PE_WIDTH*8-1:0]         i_write_data,
    input  logic                                 i_write_enable,
    input  logic                                 i_write_history_enable
);

    localparam int c_W     = `MATCH_PE_WIDTH;
    localparam int c_OFF_W = $clog2(c_W);
    localparam int c_ROW_W = SIZE_LOG2 - c_OFF_W;
    localparam int c_DEPTH = 1 << c_ROW_W;
    localparam int c_LEN_W = `MAX_MATCH_LEN_LOG2 + 1;
    localparam int c_IDX_W = SCOREBOARD_ENTRY_INDEX;
    // Compare gets its own register only when the latency budget allows it.
    localparam int c_DLY   = (NBPIPE >= 3) ? NBPIPE - 2 : NBPIPE - 1;

    logic [c_OFF_W-1:0]  w_head_off, w_hist_off;
    logic [c_ROW_W-1:0]  w_head_row, w_hist_row, w_wr_row;
    logic                w_unused;

    assign w_head_off = i_head_addr[c_OFF_W-1:0];
    assign w_hist_off = i_history_addr[c_OFF_W-1:0];
    assign w_head_row = i_head_addr[SIZE_LOG2-1:c_OFF_W];
    assign w_hist_row = i_history_addr[SIZE_LOG2-1:c_OFF_W];
    assign w_wr_row   = i_write_addr[SIZE_LOG2-1:c_OFF_W];
    assign w_unused   = ^{i_head_addr, i_history_addr, i_write_addr};

    logic                r_s1_valid;
    logic [c_IDX_W-1:0]  r_s1_idx;
    logic                r_s1_last;
    logic [c_OFF_W-1:0]  r_s1_head_off, r_s1_hist_off;
    logic [c_W*8-1:0]    w_head_bytes, w_hist_bytes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_idx      <= '0;
            r_s1_last     <= 1'b0;
            r_s1_head_off <= '0;
            r_s1_hist_off <= '0;
        end else begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_idx      <= i_idx;
                r_s1_last     <= i_last;
                r_s1_head_off <= w_head_off;
                r_s1_hist_off <= w_hist_off;
            end
        end
    end

    for (genvar b = 0; b < c_W; b++) begin : g_bank
        logic [7:0]         r_head_mem [c_DEPTH];
        logic [7:0]         r_hist_mem [c_DEPTH];
        logic [7:0]         r_head_byte, r_hist_byte;
        logic [c_ROW_W-1:0] w_head_rd_row, w_hist_rd_row;

        // Banks below the start offset belong to the following row.
        assign w_head_rd_row = (c_OFF_W'(b) >= w_head_off) ? w_head_row
                                                           : w_head_row + c_ROW_W'(1);
        assign w_hist_rd_row = (c_OFF_W'(b) >= w_hist_off) ? w_hist_row
                                                           : w_hist_row + c_ROW_W'(1);

        always_ff @(posedge clk) begin
            if (i_write_enable) begin
                r_head_mem[w_wr_row] <= i_write_data[8*b +: 8];
                if (i_write_history_enable)
                    r_hist_mem[w_wr_row] <= i_write_data[8*b +: 8];
            end
            if (i_valid) begin
                r_head_byte <= r_head_mem[w_head_rd_row];
                r_hist_byte <= r_hist_mem[w_hist_rd_row];
            end
        end

        assign w_head_bytes[8*b +: 8] = r_head_byte;
        assign w_hist_bytes[8*b +: 8] = r_hist_byte;
    end

    logic [c_W-1:0]      w_eq;
    logic [c_OFF_W-1:0]  w_hsel, w_ysel;

    always_comb begin
        w_eq   = '0;
        w_hsel = '0;
        w_ysel = '0;
        for (int k = 0; k < c_W; k++) begin
            w_hsel  = r_s1_head_off + c_OFF_W'(k);
            w_ysel  = r_s1_hist_off + c_OFF_W'(k);
            w_eq[k] = (w_head_bytes[8*w_hsel +: 8] == w_hist_bytes[8*w_ysel +: 8]);
        end
    end

    logic                w_cnt_valid;
    logic [c_IDX_W-1:0]  w_cnt_idx;
    logic                w_cnt_last;
    logic [c_W-1:0]      w_cnt_eq;

    if (NBPIPE >= 3) begin : g_eq_reg
        logic                r_s2_valid;
        logic [c_IDX_W-1:0]  r_s2_idx;
        logic                r_s2_last;
        logic [c_W-1:0]      r_s2_eq;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s2_valid <= 1'b0;
                r_s2_idx   <= '0;
                r_s2_last  <= 1'b0;
                r_s2_eq    <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_idx  <= r_s1_idx;
                    r_s2_last <= r_s1_last;
                    r_s2_eq   <= w_eq;
                end
            end
        end

        assign w_cnt_valid = r_s2_valid;
        assign w_cnt_idx   = r_s2_idx;
        assign w_cnt_last  = r_s2_last;
        assign w_cnt_eq    = r_s2_eq;
    end else begin : g_eq_comb
        assign w_cnt_valid = r_s1_valid;
        assign w_cnt_idx   = r_s1_idx;
        assign w_cnt_last  = r_s1_last;
        assign w_cnt_eq    = w_eq;
    end

    logic [c_LEN_W-1:0]  w_len;
    logic                w_run;

    always_comb begin
        w_len = '0;
        w_run = 1'b1;
        for (int k = 0; k < c_W; k++) begin
            w_run = w_run & w_cnt_eq[k];
            if (w_run)
                w_len = w_len + c_LEN_W'(1);
        end
    end

    logic [c_DLY-1:0]                r_dly_valid;
    logic [c_DLY-1:0][c_IDX_W-1:0]   r_dly_idx;
    logic [c_DLY-1:0]                r_dly_last;
    logic [c_DLY-1:0][c_LEN_W-1:0]   r_dly_len;

    // Tag/length stages only load on a valid beat so idle outputs hold value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly_valid <= '0;
            r_dly_idx   <= '0;
            r_dly_last  <= '0;
            r_dly_len   <= '0;
        end else begin
            r_dly_valid[0] <= w_cnt_valid;
            if (w_cnt_valid) begin
                r_dly_idx[0]  <= w_cnt_idx;
                r_dly_last[0] <= w_cnt_last;
                r_dly_len[0]  <= w_len;
            end
            for (int i = 1; i < c_DLY; i++) begin
                r_dly_valid[i] <= r_dly_valid[i-1];
                if (r_dly_valid[i-1]) begin
                    r_dly_idx[i]  <= r_dly_idx[i-1];
                    r_dly_last[i] <= r_dly_last[i-1];
                    r_dly_len[i]  <= r_dly_len[i-1];
                end
            end
        end
    end

    assign o_valid     = r_dly_valid[c_DLY-1];
    assign o_idx       = r_dly_idx[c_DLY-1];
    assign o_last      = r_dly_last[c_DLY-1];
    assign o_match_len = r_dly_len[c_DLY-1];

endmodule

`default_nettype wire

// File: tb/tb_match_pe_pipe.sv
// ============================================================================
// Module   : tb_match_pe_pipe
// Brief    : Directed + random self-checking bench for match_pe_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 15
`endif
`ifndef MATCH_PE_WIDTH
`define MATCH_PE_WIDTH 8
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 3
`endif

module tb_match_pe_pipe;

    localparam int W      = `MATCH_PE_WIDTH;
    localparam int NBPIPE = 3;
    localparam int SLOG2  = 15;
    localparam int SIZE   = 1 << SLOG2;
    localparam int NEXP   = 16384;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          i_valid = 1'b0;
    logic [0:0]                    i_idx = '0;
    logic                          i_last = 1'b0;
    logic [`ADDR_WIDTH-1:0]        i_head_addr = '0;
    logic [`ADDR_WIDTH-1:0]        i_history_addr = '0;
    logic                          o_valid;
    logic                          o_last;
    logic [0:0]                    o_idx;
    logic [`MAX_MATCH_LEN_LOG2:0]  o_match_len;
    logic [`ADDR_WIDTH-1:0]        i_write_addr = '0;
    logic [W*8-1:0]                i_write_data = '0;
    logic                          i_write_enable = 1'b0;
    logic                          i_write_history_enable = 1'b0;

    match_pe_pipe #(
        .SCOREBOARD_ENTRY_INDEX (1),
        .NBPIPE                 (NBPIPE),
        .SIZE_LOG2              (SLOG2)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .i_valid                (i_valid),
        .i_idx                  (i_idx),
        .i_last                 (i_last),
        .i_head_addr            (i_head_addr),
        .i_history_addr         (i_history_addr),
        .o_valid                (o_valid),
        .o_last                 (o_last),
        .o_idx                  (o_idx),
        .o_match_len            (o_match_len),
        .i_write_addr           (i_write_addr),
        .i_write_data           (i_write_data),
        .i_write_enable         (i_write_enable),
        .i_write_history_enable (i_write_history_enable)
    );

    always #5 clk = ~clk;

    // Byte-addressed reference copies of the two windows.
    logic [7:0] m_head [SIZE];
    logic [7:0] m_hist [SIZE];

    bit         exp_v    [NEXP];
    logic [0:0] exp_idx  [NEXP];
    logic       exp_last [NEXP];
    logic [3:0] exp_len  [NEXP];

    int cyc      = 0;
    int n_cmp    = 0;
    int n_err    = 0;
    bit in_reset = 1'b1;

    function automatic int model_len(int ha, int ya);
        int n = 0;
        bit run = 1'b1;
        for (int k = 0; k < W; k++) begin
            if (run && m_head[(ha + k) % SIZE] == m_hist[(ya + k) % SIZE]) n++;
            else run = 1'b0;
        end
        return n;
    endfunction

    task automatic check_outputs();
        n_cmp++;
        assert (o_valid === exp_v[cyc]) else begin
            n_err++;
            $error("FAIL valid cyc=%0d observed=%b expected=%b", cyc, o_valid, exp_v[cyc]);
        end
        if (exp_v[cyc]) begin
            n_cmp++;
            assert (o_idx === exp_idx[cyc]) else begin
                n_err++;
                $error("FAIL idx cyc=%0d observed=%0d expected=%0d", cyc, o_idx, exp_idx[cyc]);
            end
            n_cmp++;
            assert (o_last === exp_last[cyc]) else begin
                n_err++;
                $error("FAIL last cyc=%0d observed=%b expected=%b", cyc, o_last, exp_last[cyc]);
            end
            n_cmp++;
            assert (o_match_len === exp_len[cyc]) else begin
                n_err++;
                $error("FAIL len cyc=%0d observed=%0d expected=%0d", cyc, o_match_len, exp_len[cyc]);
            end
        end
        if (in_reset) begin
            n_cmp++;
            assert ({o_idx, o_last, o_match_len} === 6'd0) else begin
                n_err++;
                $error("FAIL reset_tags cyc=%0d observed=%h expected=0", cyc,
                       {o_idx, o_last, o_match_len});
            end
        end
    endtask

    // Advance one clock: model the sampled inputs, then check the outputs.
    task automatic step();
        int base;
        if (i_valid && rst_n) begin
            exp_v[cyc + NBPIPE]    = 1'b1;
            exp_idx[cyc + NBPIPE]  = i_idx;
            exp_last[cyc + NBPIPE] = i_last;
            exp_len[cyc + NBPIPE]  = 4'(model_len(int'(i_head_addr), int'(i_history_addr)));
        end
        if (i_write_enable) begin
            base = int'(i_write_addr) & ~(W - 1) & (SIZE - 1);
            for (int k = 0; k < W; k++) begin
                m_head[base + k] = i_write_data[8*k +: 8];
                if (i_write_history_enable) m_hist[base + k] = i_write_data[8*k +: 8];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        i_valid                = 1'b0;
        i_write_enable         = 1'b0;
        i_write_history_enable = 1'b0;
    endtask

    task automatic wr(input int a, input logic [63:0] d, input bit both);
        i_write_addr           = a[`ADDR_WIDTH-1:0];
        i_write_data           = d;
        i_write_enable         = 1'b1;
        i_write_history_enable = both;
    endtask

    task automatic issue(input int h, input int y, input int idx, input bit last);
        i_valid        = 1'b1;
        i_head_addr    = h[`ADDR_WIDTH-1:0];
        i_history_addr = y[`ADDR_WIDTH-1:0];
        i_idx          = idx[0:0];
        i_last         = last;
    endtask

    function automatic logic [63:0] rand_bits01();
        logic [63:0] d = '0;
        for (int k = 0; k < W; k++) d[8*k +: 8] = 8'($urandom_range(0, 1));
        return d;
    endfunction

    initial begin
        // Reset state.
        repeat (3) step();
        in_reset = 1'b0;
        rst_n    = 1'b1;

        // Fill both copies so every address has a defined value.
        for (int r = 0; r < SIZE / W; r++) begin
            wr(r * W, rand_bits01(), 1'b1);
            step();
        end

        // Aligned full match.
        wr(0, 64'h1716151413121110, 1'b1); step();
        issue(0, 0, 1, 1'b1); step();
        repeat (NBPIPE) step();

        // Partial match of three bytes.
        wr(8, 64'hFFFFFFFFFF121110, 1'b1); step();
        wr(8, 64'h1F1E1D1C1B1A1918, 1'b0); step();
        issue(0, 8, 0, 1'b0); step();
        repeat (NBPIPE) step();

        // Unaligned row straddle.
        wr(0, 64'h0706050403020100, 1'b1); step();
        wr(8, 64'h0F0E0D0C0B0A0908, 1'b1); step();
        issue(5, 5, 1, 1'b0); step();
        issue(5, 6, 0, 1'b1); step();
        repeat (NBPIPE) step();

        // Window wrap.
        wr(SIZE - 8, 64'hAAAAAAAAAAAAAAAA, 1'b1); step();
        wr(0, 64'hBBBBBBBBBBBBBBBB, 1'b1); step();
        wr(64, 64'hBBBBBBBBAAAAAAAA, 1'b1); step();
        issue(SIZE - 4, SIZE - 4, 1, 1'b1); step();
        issue(SIZE - 4, 64, 0, 1'b0); step();
        issue(SIZE - 4, SIZE - 8, 1, 1'b0); step();
        repeat (NBPIPE) step();

        // Back-to-back beats.
        issue(5, 5, 0, 1'b0); step();
        issue(100, 200, 1, 1'b0); step();
        issue(SIZE - 3, 1, 0, 1'b0); step();
        issue(64, 64, 1, 1'b1); step();
        repeat (NBPIPE + 1) step();

        // Reset with two beats in flight.
        issue(0, 0, 1, 1'b1); step();
        issue(5, 5, 1, 1'b1); step();
        rst_n    = 1'b0;
        in_reset = 1'b1;
        for (int c = cyc; c < cyc + NBPIPE + 3; c++) exp_v[c] = 1'b0;
        #1;
        n_cmp++;
        assert (o_valid === 1'b0) else begin
            n_err++;
            $error("FAIL async_reset observed=%b expected=0", o_valid);
        end
        repeat (2) step();
        rst_n    = 1'b1;
        in_reset = 1'b0;
        step();
        issue(5, 5, 1, 1'b0); step();
        repeat (NBPIPE) step();

        // Read-during-write returns the old data.
        wr(0, 64'hCCCCCCCCCCCCCCCC, 1'b0);
        issue(0, 0, 0, 1'b1); step();
        issue(0, 0, 1, 1'b0); step();
        repeat (NBPIPE) step();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            int h, y;
            if ($urandom_range(0, 2) == 0)
                wr($urandom_range(0, SIZE - 1), rand_bits01(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) != 0) begin
                h = $urandom_range(0, SIZE - 1);
                y = ($urandom_range(0, 1) == 0) ? h : $urandom_range(0, SIZE - 1);
                issue(h, y, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
            end
            step();
        end
        repeat (NBPIPE + 1) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
